// File: rtl/audio_codec_pkg.sv
// Shared audio frame constants and types for the codec TX path.
// The effect cores import this package too.
package audio_codec_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 2 * SLOT_BITS;

    localparam int POS_W  = $clog2(FRAME_BITS);
    localparam int SLOT_W = $clog2(SLOT_BITS);
    localparam int IDX_W  = $clog2(SAMPLE_W);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        WARMUP,
        RUN
    } state_e;

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider for the codec serial port.
// Produces BCLK and a one-cycle strobe on the cycle BCLK falls.
module bclk_gen #(
    parameter int BCLK_HALF = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic bclk_o,
    output logic fall_o
);

    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    always_comb begin
        wrap   = (div_q == DW'(BCLK_HALF - 1));
        div_d  = wrap ? '0 : div_q + DW'(1);
        bclk_d = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign fall_o = wrap & bclk_q;

endmodule

// File: rtl/codec_dac_tx.sv
// I2S transmitter and frame-timing master for the effect chain.
// Captures core results once per frame and shifts them out MSB-first.
module codec_dac_tx
    import audio_codec_pkg::*;
#(
    parameter int BCLK_HALF  = 8,
    parameter int VALID_BITS = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t left_in,
    input  sample_t right_in,
    input  logic    mute,
    output logic    VALID,
    output logic    BCLK,
    output logic    LRCLK,
    output logic    SDATA
);

    logic             fall;
    logic [POS_W-1:0] pos_q, pos_d;
    state_e           state_q, state_d;
    sample_t          shadow_l_q, shadow_l_d;
    sample_t          shadow_r_q, shadow_r_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             valid_q, valid_d;
    logic [SLOT_W-1:0] slot_bit;
    logic [IDX_W-1:0]  idx;
    sample_t          chan;
    logic             wrap;

    bclk_gen #(
        .BCLK_HALF(BCLK_HALF)
    ) u_bclk (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bclk_o(BCLK),
        .fall_o(fall)
    );

    always_comb begin
        pos_d      = pos_q;
        state_d    = state_q;
        shadow_l_d = shadow_l_q;
        shadow_r_d = shadow_r_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        valid_d    = valid_q;
        slot_bit   = '0;
        idx        = '0;
        chan       = '0;
        wrap       = (pos_q == POS_W'(FRAME_BITS - 1));
        if (fall) begin
            pos_d = wrap ? '0 : pos_q + POS_W'(1);
            if (wrap) begin
                state_d    = RUN;
                shadow_l_d = mute ? '0 : left_in;
                shadow_r_d = mute ? '0 : right_in;
            end
            // Slot bit 0 is the I2S delay bit; data sits in bits 1..SAMPLE_W.
            slot_bit = pos_d[SLOT_W-1:0];
            idx      = IDX_W'(SLOT_W'(SAMPLE_W) - slot_bit);
            lrclk_d  = (pos_d >= POS_W'(SLOT_BITS));
            chan     = lrclk_d ? shadow_r_q : shadow_l_q;
            sdata_d  = (state_d == RUN) && (slot_bit != '0)
                    && (slot_bit <= SLOT_W'(SAMPLE_W)) && chan[idx];
            valid_d  = (state_d == RUN) && (pos_d < POS_W'(VALID_BITS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= POS_W'(FRAME_BITS - 1);
            state_q    <= WARMUP;
            shadow_l_q <= '0;
            shadow_r_q <= '0;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            state_q    <= state_d;
            shadow_l_q <= shadow_l_d;
            shadow_r_q <= shadow_r_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            valid_q    <= valid_d;
        end
    end

    assign LRCLK = lrclk_q;
    assign SDATA = sdata_q;
    assign VALID = valid_q;

endmodule
